// File: rtl/pong_pkg.sv
// Shared types and geometry for the Pong ball engine.
package pong_pkg;

    localparam int COORD_W     = 10;
    localparam int NEXT_W      = 12;
    localparam int SPEED_W     = 4;

    localparam int FIELD_W     = 640;
    localparam int FIELD_H     = 480;
    localparam int BALL_SIZE   = 8;
    localparam int PADDLE_W    = 8;
    localparam int PADDLE_H    = 64;
    localparam int PADDLE_XL   = 16;
    localparam int PADDLE_XR   = 616;
    localparam int SPEED       = 4;
    localparam int MAX_SPEED   = 8;
    localparam int SERVE_DELAY = 30;

    localparam int CNT_W       = $clog2(SERVE_DELAY + 1);
    localparam int CENTRE_X    = (FIELD_W - BALL_SIZE) / 2;
    localparam int CENTRE_Y    = (FIELD_H - BALL_SIZE) / 2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        SCORED     = 3'd3,
        HALT       = 3'd4
    } state_t;

    // Signed next coordinate so that moves below zero stay visible.
    function automatic logic signed [NEXT_W-1:0] step_pos(
        input logic [COORD_W-1:0] pos,
        input logic               dir_pos,
        input logic [SPEED_W-1:0] spd
    );
        logic signed [NEXT_W-1:0] p;
        logic signed [NEXT_W-1:0] s;
        p = signed'({{(NEXT_W-COORD_W){1'b0}}, pos});
        s = signed'({{(NEXT_W-SPEED_W){1'b0}}, spd});
        return dir_pos ? (p + s) : (p - s);
    endfunction

endpackage

// File: rtl/ball_ctrl_if.sv
// Ball engine bus: frame/serve/paddle inputs and ball/score outputs.
interface ball_ctrl_if;
    import pong_pkg::*;

    logic               frame_tick;
    logic               serve;
    logic [COORD_W-1:0] p1_y;
    logic [COORD_W-1:0] p2_y;
    logic               game_over;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic               p1vic;
    logic               p2vic;
    logic               ball_active;

    modport master (
        output frame_tick, serve, p1_y, p2_y, game_over,
        input  ball_x, ball_y, p1vic, p2vic, ball_active
    );

    modport slave (
        input  frame_tick, serve, p1_y, p2_y, game_over,
        output ball_x, ball_y, p1vic, p2vic, ball_active
    );
endinterface

// File: rtl/ball_ctrl_paddle_hit_chk.sv
// Vertical overlap test between the ball and one paddle.
module paddle_hit_chk
    import pong_pkg::*;
(
    input  logic [COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0] paddle_y,
    output logic               overlap
);

    logic [COORD_W:0] ball_bot_s;
    logic [COORD_W:0] pad_bot_s;

    assign ball_bot_s = {1'b0, ball_y}   + (COORD_W+1)'(BALL_SIZE);
    assign pad_bot_s  = {1'b0, paddle_y} + (COORD_W+1)'(PADDLE_H);
    assign overlap    = (ball_bot_s > {1'b0, paddle_y}) && ({1'b0, ball_y} < pad_bot_s);

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball engine: serve delay, motion, wall/paddle bounces, goal pulses.
// Optional SPEEDUP_EN: each paddle hit raises speed by one up to MAX_SPEED.
module ball_ctrl
    import pong_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    ball_ctrl_if.slave  bus
);

    localparam logic [COORD_W-1:0]       CX         = COORD_W'(CENTRE_X);
    localparam logic [COORD_W-1:0]       CY         = COORD_W'(CENTRE_Y);
    localparam logic [COORD_W-1:0]       Y_MAX_C    = COORD_W'(FIELD_H - BALL_SIZE);
    localparam logic [COORD_W-1:0]       L_STOP_C   = COORD_W'(PADDLE_XL + PADDLE_W);
    localparam logic [COORD_W-1:0]       R_STOP_C   = COORD_W'(PADDLE_XR - BALL_SIZE);
    localparam logic [CNT_W-1:0]         SERVE_LAST = CNT_W'(SERVE_DELAY);
    localparam logic signed [NEXT_W-1:0] ZERO_S     = NEXT_W'(0);
    localparam logic signed [NEXT_W-1:0] BALL_S     = NEXT_W'(BALL_SIZE);
    localparam logic signed [NEXT_W-1:0] L_FACE_S   = NEXT_W'(PADDLE_XL + PADDLE_W);
    localparam logic signed [NEXT_W-1:0] R_FACE_S   = NEXT_W'(PADDLE_XR);
    localparam logic signed [NEXT_W-1:0] X_GOAL_S   = NEXT_W'(FIELD_W - BALL_SIZE);
    localparam logic signed [NEXT_W-1:0] Y_MAX_S    = NEXT_W'(FIELD_H - BALL_SIZE);

    state_t               state_r, state_s;
    logic [COORD_W-1:0]   x_r, x_s, y_r, y_s;
    logic                 dir_x_r, dir_x_s, dir_y_r, dir_y_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 p1vic_r, p1vic_s, p2vic_r, p2vic_s;
    logic                 active_r;
    logic [SPEED_W-1:0]   speed_s;
    logic signed [NEXT_W-1:0] xs_s, nx_s, ny_s;
    logic                 ov1_s, ov2_s;
    logic                 hit_l_s, hit_r_s, goal_l_s, goal_r_s;

    paddle_hit_chk u_chk_p1 (.ball_y(y_r), .paddle_y(bus.p1_y), .overlap(ov1_s));
    paddle_hit_chk u_chk_p2 (.ball_y(y_r), .paddle_y(bus.p2_y), .overlap(ov2_s));

    assign xs_s = signed'({{(NEXT_W-COORD_W){1'b0}}, x_r});
    assign nx_s = step_pos(x_r, dir_x_r, speed_s);
    assign ny_s = step_pos(y_r, dir_y_r, speed_s);

    // Paddle contact needs the ball to cross the face on this move; a ball already past it scores.
    assign hit_l_s  = !dir_x_r && (xs_s >= L_FACE_S) && (nx_s < L_FACE_S) && ov1_s;
    assign goal_l_s = !dir_x_r && !hit_l_s && (nx_s <= ZERO_S);
    assign hit_r_s  = dir_x_r && ((xs_s + BALL_S) <= R_FACE_S) && ((nx_s + BALL_S) > R_FACE_S) && ov2_s;
    assign goal_r_s = dir_x_r && !hit_r_s && (nx_s >= X_GOAL_S);

`ifdef SPEEDUP_EN
    logic [SPEED_W-1:0] speed_r, speed_nxt_s;
    logic               hit_tick_s;

    assign hit_tick_s = (state_r == PLAY) && bus.frame_tick && !bus.game_over && (hit_l_s || hit_r_s);
    assign speed_s    = speed_r;

    // Speed reloads at each serve and climbs on every paddle contact.
    always_comb begin
        speed_nxt_s = speed_r;
        if ((state_r == IDLE) && bus.serve && !bus.game_over) begin
            speed_nxt_s = SPEED_W'(SPEED);
        end else if (hit_tick_s && (speed_r < SPEED_W'(MAX_SPEED))) begin
            speed_nxt_s = speed_r + SPEED_W'(1);
        end else begin
            speed_nxt_s = speed_r;
        end
    end

    // Speed register
    always_ff @(posedge clock) begin
        if (reset) begin
            speed_r <= SPEED_W'(SPEED);
        end else begin
            speed_r <= speed_nxt_s;
        end
    end
`else
    assign speed_s = SPEED_W'(SPEED);
`endif

    // Next-state and next-position logic
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        dir_x_s = dir_x_r;
        dir_y_s = dir_y_r;
        cnt_s   = cnt_r;
        p1vic_s = 1'b0;
        p2vic_s = 1'b0;
        if (bus.game_over) begin
            state_s = HALT;
            x_s     = CX;
            y_s     = CY;
        end else begin
            case (state_r)
                IDLE: begin
                    x_s = CX;
                    y_s = CY;
                    if (bus.serve) begin
                        state_s = SERVE_WAIT;
                        cnt_s   = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                SERVE_WAIT: begin
                    if (bus.frame_tick) begin
                        cnt_s = cnt_r + CNT_W'(1);
                        if (cnt_s == SERVE_LAST) begin
                            state_s = PLAY;
                        end else begin
                            state_s = SERVE_WAIT;
                        end
                    end else begin
                        state_s = SERVE_WAIT;
                    end
                end
                PLAY: begin
                    if (bus.frame_tick) begin
                        if (ny_s < ZERO_S) begin
                            y_s     = '0;
                            dir_y_s = 1'b1;
                        end else if (ny_s > Y_MAX_S) begin
                            y_s     = Y_MAX_C;
                            dir_y_s = 1'b0;
                        end else begin
                            y_s     = ny_s[COORD_W-1:0];
                            dir_y_s = dir_y_r;
                        end
                        // Goals recentre and serve back toward the conceding side.
                        if (hit_l_s) begin
                            x_s     = L_STOP_C;
                            dir_x_s = 1'b1;
                        end else if (goal_l_s) begin
                            state_s = SCORED;
                            p2vic_s = 1'b1;
                            x_s     = CX;
                            y_s     = CY;
                            dir_x_s = 1'b0;
                            dir_y_s = dir_y_r;
                        end else if (hit_r_s) begin
                            x_s     = R_STOP_C;
                            dir_x_s = 1'b0;
                        end else if (goal_r_s) begin
                            state_s = SCORED;
                            p1vic_s = 1'b1;
                            x_s     = CX;
                            y_s     = CY;
                            dir_x_s = 1'b1;
                            dir_y_s = dir_y_r;
                        end else begin
                            x_s = nx_s[COORD_W-1:0];
                        end
                    end else begin
                        state_s = PLAY;
                    end
                end
                SCORED: begin
                    state_s = IDLE;
                end
                HALT: begin
                    state_s = HALT;
                end
                default: begin
                    state_s = IDLE;
                    x_s     = CX;
                    y_s     = CY;
                end
            endcase
        end
    end

    // State, motion and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            x_r      <= CX;
            y_r      <= CY;
            dir_x_r  <= 1'b1;
            dir_y_r  <= 1'b1;
            cnt_r    <= '0;
            p1vic_r  <= 1'b0;
            p2vic_r  <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            x_r      <= x_s;
            y_r      <= y_s;
            dir_x_r  <= dir_x_s;
            dir_y_r  <= dir_y_s;
            cnt_r    <= cnt_s;
            p1vic_r  <= p1vic_s;
            p2vic_r  <= p2vic_s;
            active_r <= (state_s == PLAY);
        end
    end

    assign bus.ball_x      = x_r;
    assign bus.ball_y      = y_r;
    assign bus.p1vic       = p1vic_r;
    assign bus.p2vic       = p2vic_r;
    assign bus.ball_active = active_r;

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: directed scenarios plus randomized play against a rule model.
module tb_ball_ctrl;

    localparam int CX = 316;
    localparam int CY = 236;
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_PLAY = 2, PH_SCORED = 3, PH_HALT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ball_ctrl_if bus();
    ball_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    int m_x, m_y, m_dx, m_dy, m_spd, m_cnt, m_phase;
    bit m_p1vic, m_p2vic, m_active;

    task automatic model_reset();
        m_x = CX; m_y = CY; m_dx = 1; m_dy = 1; m_spd = 4; m_cnt = 0;
        m_phase = PH_IDLE; m_p1vic = 1'b0; m_p2vic = 1'b0; m_active = 1'b0;
    endtask

    // One clock of the game rules, given the inputs present before the edge.
    task automatic model_step(input bit tick, input bit srv, input bit go, input int py1, input int py2);
        int nx, ny, ty, tdy;
        bit ov1, ov2, hit, goal;
        m_p1vic = 1'b0;
        m_p2vic = 1'b0;
        if (go) begin
            m_phase = PH_HALT; m_x = CX; m_y = CY;
        end else if (m_phase == PH_IDLE) begin
            if (srv) begin m_phase = PH_WAIT; m_cnt = 0; m_spd = 4; end
        end else if (m_phase == PH_WAIT) begin
            if (tick) begin
                m_cnt++;
                if (m_cnt == 30) m_phase = PH_PLAY;
            end
        end else if (m_phase == PH_SCORED) begin
            m_phase = PH_IDLE;
        end else if (m_phase == PH_PLAY && tick) begin
            ny = m_y + m_dy * m_spd;
            nx = m_x + m_dx * m_spd;
            ov1 = (m_y + 8 > py1) && (m_y < py1 + 64);
            ov2 = (m_y + 8 > py2) && (m_y < py2 + 64);
            if (ny < 0) begin ty = 0; tdy = 1; end
            else if (ny > 472) begin ty = 472; tdy = -1; end
            else begin ty = ny; tdy = m_dy; end
            hit = 1'b0; goal = 1'b0;
            if (m_dx < 0) begin
                if (m_x >= 24 && nx < 24 && ov1) begin m_x = 24; m_dx = 1; hit = 1'b1; end
                else if (nx <= 0) begin goal = 1'b1; m_p2vic = 1'b1; m_dx = -1; end
                else m_x = nx;
            end else begin
                if (m_x + 8 <= 616 && nx + 8 > 616 && ov2) begin m_x = 608; m_dx = -1; hit = 1'b1; end
                else if (nx >= 632) begin goal = 1'b1; m_p1vic = 1'b1; m_dx = 1; end
                else m_x = nx;
            end
            if (goal) begin m_phase = PH_SCORED; m_x = CX; m_y = CY; end
            else begin m_y = ty; m_dy = tdy; end
`ifdef SPEEDUP_EN
            if (hit && m_spd < 8) m_spd++;
`else
            if (hit) m_spd = 4;
`endif
        end
        m_active = (m_phase == PH_PLAY);
    endtask

    task automatic step(input bit tick, input bit srv, input bit go);
        bus.frame_tick = tick;
        bus.serve = srv;
        bus.game_over = go;
        model_step(tick, srv, go, int'(bus.p1_y), int'(bus.p2_y));
        @(posedge clock);
        #1;
        bus.frame_tick = 1'b0;
        bus.serve = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.frame_tick = 1'b0; bus.serve = 1'b0; bus.game_over = 1'b0;
        bus.p1_y = 10'd0; bus.p2_y = 10'd0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic launch();
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 || bus.p1vic !== 1'b0 ||
            bus.p2vic !== 1'b0 || bus.ball_active !== 1'b0) begin
            failures++;
            $display("FAIL reset got x=%0d y=%0d p1=%b p2=%b act=%b want x=316 y=236 p1=0 p2=0 act=0",
                     bus.ball_x, bus.ball_y, bus.p1vic, bus.p2vic, bus.ball_active);
        end
    endtask

    task automatic test_serve_launch();
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 || bus.ball_active !== 1'b0) begin
            failures++;
            $display("FAIL serve_accept got x=%0d y=%0d act=%b want x=316 y=236 act=0",
                     bus.ball_x, bus.ball_y, bus.ball_active);
        end
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 || bus.ball_active !== (k == 30)) begin
                failures++;
                $display("FAIL serve_wait tick=%0d got x=%0d y=%0d act=%b want x=316 y=236 act=%b",
                         k, bus.ball_x, bus.ball_y, bus.ball_active, (k == 30));
            end
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.ball_x !== 10'd320 || bus.ball_y !== 10'd240 || bus.ball_active !== 1'b1) begin
            failures++;
            $display("FAIL first_move got x=%0d y=%0d act=%b want x=320 y=240 act=1",
                     bus.ball_x, bus.ball_y, bus.ball_active);
        end
    endtask

    task automatic test_goal_pulse();
        int p1_hi, p2_hi, n;
        bit seen;
        do_reset();
        launch();
        p1_hi = 0; p2_hi = 0; seen = 1'b0; n = 0;
        // Right paddle always kept clear of the ball, so the ball exits right.
        while (n < 3000 && !(seen && m_phase == PH_IDLE)) begin
            bus.p2_y = (m_y >= 240) ? 10'd0 : 10'd400;
            step(n[0], 1'b0, 1'b0);
            if (bus.p1vic === 1'b1) p1_hi++;
            if (bus.p2vic === 1'b1) p2_hi++;
            if (m_p1vic) seen = 1'b1;
            checks++;
            if (bus.ball_x !== 10'(m_x) || bus.ball_y !== 10'(m_y) || bus.p1vic !== m_p1vic ||
                bus.p2vic !== m_p2vic || bus.ball_active !== m_active) begin
                failures++;
                $display("FAIL goal_track n=%0d got x=%0d y=%0d p1=%b p2=%b act=%b want x=%0d y=%0d p1=%b p2=%b act=%b",
                         n, bus.ball_x, bus.ball_y, bus.p1vic, bus.p2vic, bus.ball_active,
                         m_x, m_y, m_p1vic, m_p2vic, m_active);
            end
            n++;
        end
        checks++;
        if (!seen || p1_hi != 1 || p2_hi != 0) begin
            failures++;
            $display("FAIL goal_pulse got p1_cycles=%0d p2_cycles=%0d reached=%b want p1_cycles=1 p2_cycles=0 reached=1",
                     p1_hi, p2_hi, seen);
        end
        checks++;
        if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 || bus.ball_active !== 1'b0) begin
            failures++;
            $display("FAIL goal_recentre got x=%0d y=%0d act=%b want x=316 y=236 act=0",
                     bus.ball_x, bus.ball_y, bus.ball_active);
        end
        launch();
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.ball_x !== 10'd320) begin
            failures++;
            $display("FAIL relaunch_dir got x=%0d want x=320", bus.ball_x);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        launch();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 || bus.ball_active !== 1'b0 ||
            bus.p1vic !== 1'b0 || bus.p2vic !== 1'b0) begin
            failures++;
            $display("FAIL halt_entry got x=%0d y=%0d act=%b p1=%b p2=%b want x=316 y=236 act=0 p1=0 p2=0",
                     bus.ball_x, bus.ball_y, bus.ball_active, bus.p1vic, bus.p2vic);
        end
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (k < 20));
            checks++;
            if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 || bus.ball_active !== 1'b0 ||
                bus.p1vic !== 1'b0 || bus.p2vic !== 1'b0) begin
                failures++;
                $display("FAIL halt_hold k=%0d got x=%0d y=%0d act=%b p1=%b p2=%b want x=316 y=236 act=0 p1=0 p2=0",
                         k, bus.ball_x, bus.ball_y, bus.ball_active, bus.p1vic, bus.p2vic);
            end
        end
        do_reset();
        launch();
        checks++;
        if (bus.ball_active !== 1'b1) begin
            failures++;
            $display("FAIL halt_reset_exit got act=%b want act=1", bus.ball_active);
        end
    endtask

    task automatic test_random_play();
        int off;
        do_reset();
        for (int n = 0; n < 20000; n++) begin
            if ($urandom_range(0, 7) != 0) begin
                off = m_y - int'($urandom_range(0, 60));
                bus.p1_y = 10'((off < 0) ? 0 : off);
                off = m_y - int'($urandom_range(0, 60));
                bus.p2_y = 10'((off < 0) ? 0 : off);
            end else begin
                bus.p1_y = 10'($urandom_range(0, 416));
                bus.p2_y = 10'($urandom_range(0, 416));
            end
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0), 1'b0);
            checks++;
            if (bus.ball_x !== 10'(m_x) || bus.ball_y !== 10'(m_y) || bus.p1vic !== m_p1vic ||
                bus.p2vic !== m_p2vic || bus.ball_active !== m_active) begin
                failures++;
                $display("FAIL random_play n=%0d got x=%0d y=%0d p1=%b p2=%b act=%b want x=%0d y=%0d p1=%b p2=%b act=%b",
                         n, bus.ball_x, bus.ball_y, bus.p1vic, bus.p2vic, bus.ball_active,
                         m_x, m_y, m_p1vic, m_p2vic, m_active);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_serve_launch();
        test_goal_pulse();
        test_game_over();
        test_random_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
